// File: rtl/ddr5_pkg.sv
// Shared definitions for the DDR5 bus arbiter: command codes, bus widths, FSM state type.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ddr5_pkg;

    // Command nibble placed in system_bus[31:28] of the command word
    localparam logic [3:0] CMD_WRITE = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0010;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 64;
    localparam int BUS_W  = 32;

    localparam int DEFAULT_READY_TIMEOUT = 20;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WLO,
        WHI,
        END,
        WAIT_RDY
    } state_t;

    // Layout of the first word of every transaction on system_bus
    typedef struct packed {
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } cmd_word_t;

endpackage

// File: rtl/ddr5_rr_arbiter.sv
// Round-robin pick among requesters, searching upward from last_grant+1 with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the grant is used this cycle.
//
// Ports:
//   valid      - per-requester request vector
//   last_grant - index of the previous winner (search starts one above it)
//   grant      - one-hot winner, all zero when nothing is valid
//   grant_idx  - binary index of the winner, 0 when nothing is valid
module ddr5_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // Offsets 1..NUM_REQ visit every requester once, ending on last_grant
    // itself, so a lone requester can win back-to-back.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!found && valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ddr5_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto the 32-bit system bus of the DDR5 memory controller.
// Latency: first bus word one cycle after acceptance; write = 4 bus words, read = 2, then wait for ready.
// Backpressure: req_ready only in IDLE; requesters hold req_valid until accepted; ready wait bounded by READY_TIMEOUT.
//
// Ports:
//   clk, reset             - single clock, synchronous active-high reset
//   req_valid/req_write    - per-requester request and direction (1 = write)
//   req_addr/req_wdata     - packed per-requester address (28b) and write data (64b)
//   req_ready              - one-hot acceptance, combinational, only in IDLE
//   system_bus             - registered command/data word to the controller
//   memory_interface_ready - completion from the controller, only looked at in WAIT_RDY
//   grant_id               - requester owning the current/last transaction
//   busy                   - high whenever the FSM is not in IDLE
//   timeout_err            - sticky, set when ready never arrives; cleared by reset only
module ddr5_bus_arbiter
    import ddr5_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int READY_TIMEOUT = DEFAULT_READY_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BUS_W-1:0]             system_bus,
    input  logic                         memory_interface_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(READY_TIMEOUT + 1);

    state_t            state;
    logic [IDX_W-1:0]  last_grant;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;

    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    cmd_word_t         cmd_word;

    ddr5_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .grant_idx  (rr_idx)
    );

    // Acceptance is offered only while idle and never during a reset cycle,
    // so a handshake always corresponds to a real latch of the request.
    assign req_ready = (state == IDLE && !reset) ? rr_grant : '0;

    // One-hot AND-OR mux of the winning requester's fields
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        cmd_word.cmd  = sel_write ? CMD_WRITE : CMD_READ;
        cmd_word.addr = sel_addr;
    end

    // system_bus and busy are loaded with the value belonging to the state
    // being entered, so each bus word is visible for the whole cycle its
    // state is active. The address is only needed for the command word, so
    // it is captured directly into system_bus at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            system_bus  <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            lat_write   <= 1'b0;
            lat_wdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        lat_write  <= sel_write;
                        lat_wdata  <= sel_wdata;
                        grant_id   <= rr_idx;
                        last_grant <= rr_idx;
                        system_bus <= cmd_word;
                        busy       <= 1'b1;
                        state      <= CMD;
                    end
                end
                CMD: begin
                    if (lat_write) begin
                        system_bus <= lat_wdata[BUS_W-1:0];
                        state      <= WLO;
                    end else begin
                        system_bus <= '0;
                        state      <= END;
                    end
                end
                WLO: begin
                    system_bus <= lat_wdata[DATA_W-1:BUS_W];
                    state      <= WHI;
                end
                WHI: begin
                    system_bus <= '0;
                    state      <= END;
                end
                END: begin
                    system_bus <= '0;
                    wait_cnt   <= CNT_W'(1);
                    state      <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    // Ready on the final counted cycle still wins over the timeout
                    if (memory_interface_ready) begin
                        wait_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (wait_cnt == CNT_W'(READY_TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    system_bus <= '0;
                    wait_cnt   <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
